bcd_rtc_card: RTL and testbench
===============================

BCD_RTC_CARD -- requirements
Module: bcd_rtc_card

Interface
REQ-001 SHALL have parameter CLK_HZ, default 14318181, meaning CLK_14M frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 60, meaning sub-second tick rate; it is also the DEB_COUNTER modulus.
REQ-003 SHALL have parameter HOLD_ON_RESET, default 0; 1 means the clock is stopped after reset.
REQ-004 SHALL have one clock; reset is synchronous and active-high; clock port CLK_14M, reset port RESET.
REQ-005 CLK_14M  in  1  sole clock; every register updates on its rising edge.
REQ-006 RESET  in  1  synchronous active-high reset.
REQ-007 PH_2  in  1  CPU phase 2, sampled in the CLK_14M domain.
REQ-008 DEVICE_SELECT_N  in  1  active-low select for the card's 16-byte $C0nX window.
REQ-009 ADDRESS  in  16  CPU address; only [3:0] is decoded.
REQ-010 RW_N  in  1  high = read, low = write.
REQ-011 DATA_IN  in  8  write data.
REQ-012 DATA_OUT  out  8  read data.
REQ-013 OE  out  1  equals ~DEVICE_SELECT_N.
REQ-014 RTC  in  65  host time: BCD fields in [63:0]; bit 64 is a toggle-to-load flag.

Function
REQ-015 SHALL detect a bus access on the PH_2 1->0 transition (PH_2 registered in the CLK_14M domain) while DEVICE_SELECT_N=0; exactly one access per CPU cycle.
REQ-016 Register map, SHALL be:
- 0: 0x32
- 1: 0x30
- 2: 0x3,year tens
- 3: 0x3,year ones
- 4: 0x18,month tens (1 bit)
- 5: 0x3,month ones
- 6: 0x06,weekday (0-6)
- 7: 0x0C,day tens
- 8: 0x3,day ones
- 9: 0x0C,hour tens
- A: 0x3,hour ones
- B: 0x06,min tens
- C: 0x3,min ones
- D: 0x06,sec tens
- E: 0x3,sec ones
- F: control/status
REQ-017 Control register F SHALL be: bit0 HOLD (R/W), bit1 SNAP_EN (R/W), bit6 second-elapsed flag (read-to-clear), bit7 tick flag (read-to-clear); bits 5:2 read 0.
REQ-018 DATA_OUT SHALL be combinational from the selected source: the shadow copy when SNAP_EN=1, the live counters otherwise.
REQ-019 When SNAP_EN=1, a read of address 0 SHALL copy all live fields into the shadow on the access cycle; reads 1-E then return that coherent copy.
REQ-020 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 and then emit a 1-cycle tick; the tick counter SHALL count 0..TICK_HZ-1 and emit a 1-cycle second carry on wrap; widths are derived via $clog2.
REQ-021 HOLD=1 SHALL freeze the prescaler, the tick counter and all time fields; bus writes still apply.
REQ-022 Rollover SHALL be BCD with ">=" compares: sec 59->00, min 59->00, hour 23->00, weekday 6->0.
REQ-023 Day SHALL roll from days_in_month to 01 with month+1; month 12->01 with year+1; year 99->00.
REQ-024 February SHALL have 29 days when (year tens even and ones in {0,4,8}) or (tens odd and ones in {2,6}); otherwise 28; Apr/Jun/Sep/Nov have 30; all other months 31.
REQ-025 A write to 2-E SHALL store DATA_IN masked to the field width; a write to E also clears the prescaler and the tick counter.
REQ-026 If a bus write and a second carry coincide, the write SHALL win and the carry SHALL be held in a pending bit, applied on the next cycle with no write.
REQ-027 An RTC[64] toggle (compared with its registered value) SHALL load all fields from RTC with the same bit layout as the host format, clear the prescaler, the tick counter and pending, and take priority over a bus write.
REQ-028 Reads of 1-E SHALL have no side effects; writes to 0 and 1 SHALL be ignored.

Reset
REQ-029 RESET SHALL set:
- time fields to 00-01-01 00:00:00, year 00, weekday 0
- prescaler, tick counter, pending, flags and shadow to 0
- SNAP_EN=0, HOLD=HOLD_ON_RESET
- the registered PH_2 and the RTC[64] copy to their current input values
REQ-030 RESET asserted mid-access SHALL discard the access; DATA_OUT SHALL then reflect the reset state.

Structure
REQ-031 Package rtc_pkg SHALL hold the register address constants, control bit indices, the days_in_month and leap functions, and the reset date constants.
REQ-032 SHALL contain one sub-module, rtc_prescaler (parameters CLK_HZ, TICK_HZ; outputs tick and sec_carry; inputs hold and clr).

Verification
REQ-033 Bench parameters CLK_HZ=600, TICK_HZ=60: 23:59:59 on 1999-12-31, run 1 second (600 cycles) -> reads 2000-01-01 00:00:00, weekday +1 mod 7.
REQ-034 Write 1999-02-28 23:59:59, run 1 s -> 03-01; write 2000-02-28 23:59:59 -> 02-29; write 2000-02-29 23:59:59 -> 03-01.
REQ-035 SNAP_EN=1, sec=59, read addr 0, elapse 1 s, read E/D -> 0x39/0x05 (shadow) while the live field is 0.
REQ-036 Write addr E timed on the second-carry cycle -> E holds the written value; sec tens increments one cycle later via pending.
REQ-037 Toggle RTC[64] with RTC=0x...0009_23_59_30 during a bus write to C -> the RTC value is loaded and the write is dropped.
REQ-038 HOLD=1 for 5 s -> time unchanged; tick flag 0; after HOLD=0, first second carry comes 600 cycles later.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the BCD real-time-clock card: register map,
// control bits, the packed time record, calendar helpers and reset date.
package rtc_pkg;

  // Register addresses within the 16-byte window
  localparam logic [3:0] A_CENT_H = 4'h0;
  localparam logic [3:0] A_CENT_L = 4'h1;
  localparam logic [3:0] A_YR_T   = 4'h2;
  localparam logic [3:0] A_YR_O   = 4'h3;
  localparam logic [3:0] A_MO_T   = 4'h4;
  localparam logic [3:0] A_MO_O   = 4'h5;
  localparam logic [3:0] A_WDAY   = 4'h6;
  localparam logic [3:0] A_DAY_T  = 4'h7;
  localparam logic [3:0] A_DAY_O  = 4'h8;
  localparam logic [3:0] A_HR_T   = 4'h9;
  localparam logic [3:0] A_HR_O   = 4'hA;
  localparam logic [3:0] A_MIN_T  = 4'hB;
  localparam logic [3:0] A_MIN_O  = 4'hC;
  localparam logic [3:0] A_SEC_T  = 4'hD;
  localparam logic [3:0] A_SEC_O  = 4'hE;
  localparam logic [3:0] A_CTRL   = 4'hF;

  // Control/status register bit positions
  localparam int CTRL_HOLD  = 0;
  localparam int CTRL_SNAP  = 1;
  localparam int CTRL_SECF  = 6;
  localparam int CTRL_TICKF = 7;

  // Fixed century digits returned at addresses 0 and 1
  localparam logic [7:0] CENT_H_VAL = 8'h32;
  localparam logic [7:0] CENT_L_VAL = 8'h30;

  // BCD time fields, each only as wide as its digit range needs
  typedef struct packed {
    logic [3:0] yr_t;
    logic [3:0] yr_o;
    logic       mo_t;
    logic [3:0] mo_o;
    logic [2:0] wday;
    logic [1:0] day_t;
    logic [3:0] day_o;
    logic [1:0] hr_t;
    logic [3:0] hr_o;
    logic [2:0] min_t;
    logic [3:0] min_o;
    logic [2:0] sec_t;
    logic [3:0] sec_o;
  } rtc_time_t;

  // Power-on date: year 00, month 01, day 01, 00:00:00, weekday 0
  localparam rtc_time_t RESET_TIME = '{
    yr_t: 4'd0, yr_o: 4'd0, mo_t: 1'b0, mo_o: 4'd1, wday: 3'd0,
    day_t: 2'd0, day_o: 4'd1, hr_t: 2'd0, hr_o: 4'd0,
    min_t: 3'd0, min_o: 4'd0, sec_t: 3'd0, sec_o: 4'd0};

  // Two-digit BCD year divisible by four
  function automatic logic is_leap(input logic [3:0] yr_t, input logic [3:0] yr_o);
    if (!yr_t[0]) return (yr_o == 4'd0) || (yr_o == 4'd4) || (yr_o == 4'd8);
    else          return (yr_o == 4'd2) || (yr_o == 4'd6);
  endfunction

  // Last day of the month as BCD {tens[1:0], ones[3:0]}
  function automatic logic [5:0] days_in_month(input logic mo_t, input logic [3:0] mo_o,
                                               input logic [3:0] yr_t, input logic [3:0] yr_o);
    logic [5:0] d;
    d = {2'd3, 4'd1};
    if (!mo_t) begin
      if (mo_o == 4'd2)
        d = is_leap(yr_t, yr_o) ? {2'd2, 4'd9} : {2'd2, 4'd8};
      else if ((mo_o == 4'd4) || (mo_o == 4'd6) || (mo_o == 4'd9))
        d = {2'd3, 4'd0};
    end else if (mo_o == 4'd1) begin
      d = {2'd3, 4'd0};
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_rtc_card_prescaler.sv
// Divides the card clock down to the sub-second tick and the one-second carry.
module rtc_prescaler
  import rtc_pkg::*;
#(
  parameter int CLK_HZ  = 14318181,
  parameter int TICK_HZ = 60
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hold_i,
  input  logic clr_i,
  output logic tick_o,
  output logic sec_carry_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [TW-1:0] TCK_MAX = TW'(TICK_HZ - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] tck_q, tck_d;

  // Tick fires on the last prescaler count; the carry on the last tick of a second
  assign tick_o      = ~hold_i & (pre_q == PRE_MAX);
  assign sec_carry_o = tick_o & (tck_q == TCK_MAX);

  // Next counter values: clear wins, hold freezes, otherwise count and wrap
  always_comb begin
    pre_d = pre_q;
    tck_d = tck_q;
    if (clr_i) begin
      pre_d = '0;
      tck_d = '0;
    end else if (!hold_i) begin
      if (tick_o) begin
        pre_d = '0;
        tck_d = sec_carry_o ? '0 : tck_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q <= '0;
      tck_q <= '0;
    end else begin
      pre_q <= pre_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/bcd_rtc_card.sv
// BCD real-time-clock peripheral card: bus-mapped calendar registers,
// coherent snapshot readout and host-time loading.
module bcd_rtc_card
  import rtc_pkg::*;
#(
  parameter int CLK_HZ        = 14318181,
  parameter int TICK_HZ       = 60,
  parameter int HOLD_ON_RESET = 0
) (
  input  logic        CLK_14M,
  input  logic        RESET,
  input  logic        PH_2,
  input  logic        DEVICE_SELECT_N,
  input  logic [15:0] ADDRESS,
  input  logic        RW_N,
  input  logic [7:0]  DATA_IN,
  output logic [7:0]  DATA_OUT,
  output logic        OE,
  input  logic [64:0] RTC
);

  logic      ph2_q, rtc_tog_q;
  logic      hold_q, hold_d, snap_q, snap_d, pend_q, pend_d;
  logic      secf_q, secf_d, tickf_q, tickf_d;
  rtc_time_t live_q, live_d, shad_q, shad_d, src, host_time;
  logic      access, rd_acc, wr_acc, load, pre_clr, tick, sec_carry;
  logic [3:0] addr;
  logic      unused_bits;

  assign addr   = ADDRESS[3:0];
  assign OE     = ~DEVICE_SELECT_N;
  // One access per CPU cycle: the falling edge of the registered phase-2
  assign access = ph2_q & ~PH_2 & ~DEVICE_SELECT_N;
  assign load   = RTC[64] ^ rtc_tog_q;
  assign rd_acc = access & RW_N;
  assign wr_acc = access & ~RW_N & ~load;
  assign pre_clr = load | (wr_acc & (addr == A_SEC_O));

  // Host time bytes: sec, min, hour, day, month, year, weekday from the LSB up
  assign host_time = {RTC[47:44], RTC[43:40], RTC[36], RTC[35:32], RTC[50:48],
                      RTC[29:28], RTC[27:24], RTC[21:20], RTC[19:16],
                      RTC[14:12], RTC[11:8], RTC[6:4], RTC[3:0]};
  assign unused_bits = ^{ADDRESS[15:4], RTC[63:51], RTC[39:37], RTC[31:30],
                         RTC[23:22], RTC[15], RTC[7]};

  rtc_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .clk_i       (CLK_14M),
    .rst_i       (RESET),
    .hold_i      (hold_q),
    .clr_i       (pre_clr),
    .tick_o      (tick),
    .sec_carry_o (sec_carry)
  );

  // Advance the calendar by one second with BCD rollover at every digit
  function automatic rtc_time_t next_second(input rtc_time_t t);
    rtc_time_t n;
    logic [5:0] dim;
    n   = t;
    dim = days_in_month(t.mo_t, t.mo_o, t.yr_t, t.yr_o);
    if (t.sec_o < 4'd9) n.sec_o = t.sec_o + 4'd1;
    else begin
      n.sec_o = 4'd0;
      if (t.sec_t < 3'd5) n.sec_t = t.sec_t + 3'd1;
      else begin
        n.sec_t = 3'd0;
        if (t.min_o < 4'd9) n.min_o = t.min_o + 4'd1;
        else begin
          n.min_o = 4'd0;
          if (t.min_t < 3'd5) n.min_t = t.min_t + 3'd1;
          else begin
            n.min_t = 3'd0;
            if ({t.hr_t, t.hr_o} < {2'd2, 4'd3}) begin
              if (t.hr_o < 4'd9) n.hr_o = t.hr_o + 4'd1;
              else begin
                n.hr_o = 4'd0;
                n.hr_t = t.hr_t + 2'd1;
              end
            end else begin
              n.hr_t = 2'd0;
              n.hr_o = 4'd0;
              n.wday = (t.wday >= 3'd6) ? 3'd0 : t.wday + 3'd1;
              if ({t.day_t, t.day_o} < dim) begin
                if (t.day_o < 4'd9) n.day_o = t.day_o + 4'd1;
                else begin
                  n.day_o = 4'd0;
                  n.day_t = t.day_t + 2'd1;
                end
              end else begin
                n.day_t = 2'd0;
                n.day_o = 4'd1;
                if ({t.mo_t, t.mo_o} < {1'b1, 4'd2}) begin
                  if (t.mo_o < 4'd9) n.mo_o = t.mo_o + 4'd1;
                  else begin
                    n.mo_o = 4'd0;
                    n.mo_t = 1'b1;
                  end
                end else begin
                  n.mo_t = 1'b0;
                  n.mo_o = 4'd1;
                  if (t.yr_o < 4'd9) n.yr_o = t.yr_o + 4'd1;
                  else begin
                    n.yr_o = 4'd0;
                    n.yr_t = (t.yr_t >= 4'd9) ? 4'd0 : t.yr_t + 4'd1;
                  end
                end
              end
            end
          end
        end
      end
    end
    return n;
  endfunction

  // Store a bus write into one field, truncated to that field's width
  function automatic rtc_time_t write_field(input rtc_time_t t, input logic [3:0] a,
                                            input logic [7:0] d);
    rtc_time_t n;
    n = t;
    case (a)
      A_YR_T:  n.yr_t  = d[3:0];
      A_YR_O:  n.yr_o  = d[3:0];
      A_MO_T:  n.mo_t  = d[0];
      A_MO_O:  n.mo_o  = d[3:0];
      A_WDAY:  n.wday  = d[2:0];
      A_DAY_T: n.day_t = d[1:0];
      A_DAY_O: n.day_o = d[3:0];
      A_HR_T:  n.hr_t  = d[1:0];
      A_HR_O:  n.hr_o  = d[3:0];
      A_MIN_T: n.min_t = d[2:0];
      A_MIN_O: n.min_o = d[3:0];
      A_SEC_T: n.sec_t = d[2:0];
      A_SEC_O: n.sec_o = d[3:0];
      default: n = t;
    endcase
    return n;
  endfunction

  // Read mux: digits carry a 0x3 high nibble, narrow fields are zero-extended
  always_comb begin
    src      = snap_q ? shad_q : live_q;
    DATA_OUT = 8'h00;
    case (addr)
      A_CENT_H: DATA_OUT = CENT_H_VAL;
      A_CENT_L: DATA_OUT = CENT_L_VAL;
      A_YR_T:   DATA_OUT = {4'h3, src.yr_t};
      A_YR_O:   DATA_OUT = {4'h3, src.yr_o};
      A_MO_T:   DATA_OUT = {7'd0, src.mo_t};
      A_MO_O:   DATA_OUT = {4'h3, src.mo_o};
      A_WDAY:   DATA_OUT = {5'd0, src.wday};
      A_DAY_T:  DATA_OUT = {6'd0, src.day_t};
      A_DAY_O:  DATA_OUT = {4'h3, src.day_o};
      A_HR_T:   DATA_OUT = {6'd0, src.hr_t};
      A_HR_O:   DATA_OUT = {4'h3, src.hr_o};
      A_MIN_T:  DATA_OUT = {5'd0, src.min_t};
      A_MIN_O:  DATA_OUT = {4'h3, src.min_o};
      A_SEC_T:  DATA_OUT = {5'd0, src.sec_t};
      A_SEC_O:  DATA_OUT = {4'h3, src.sec_o};
      default: begin
        DATA_OUT[CTRL_HOLD]  = hold_q;
        DATA_OUT[CTRL_SNAP]  = snap_q;
        DATA_OUT[CTRL_SECF]  = secf_q;
        DATA_OUT[CTRL_TICKF] = tickf_q;
      end
    endcase
  end

  // Next state: host load beats bus write, bus write beats (and defers) the second carry
  always_comb begin
    live_d  = live_q;
    shad_d  = shad_q;
    hold_d  = hold_q;
    snap_d  = snap_q;
    pend_d  = pend_q;
    secf_d  = secf_q;
    tickf_d = tickf_q;
    if (rd_acc && (addr == A_CTRL)) begin
      secf_d  = 1'b0;
      tickf_d = 1'b0;
    end
    if (tick)      tickf_d = 1'b1;
    if (sec_carry) secf_d  = 1'b1;
    if (rd_acc && (addr == A_CENT_H) && snap_q) shad_d = live_q;
    if (load) begin
      live_d = host_time;
      pend_d = 1'b0;
    end else if (wr_acc) begin
      live_d = write_field(live_q, addr, DATA_IN);
      if (addr == A_CTRL) begin
        hold_d = DATA_IN[CTRL_HOLD];
        snap_d = DATA_IN[CTRL_SNAP];
      end
      if (sec_carry) pend_d = 1'b1;
    end else if (!hold_q && (sec_carry || pend_q)) begin
      live_d = next_second(live_q);
      pend_d = 1'b0;
    end
  end

  // State registers; edge detectors track their inputs even through reset
  always_ff @(posedge CLK_14M) begin
    ph2_q     <= PH_2;
    rtc_tog_q <= RTC[64];
    if (RESET) begin
      live_q  <= RESET_TIME;
      shad_q  <= '0;
      hold_q  <= (HOLD_ON_RESET != 0);
      snap_q  <= 1'b0;
      pend_q  <= 1'b0;
      secf_q  <= 1'b0;
      tickf_q <= 1'b0;
    end else begin
      live_q  <= live_d;
      shad_q  <= shad_d;
      hold_q  <= hold_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      secf_q  <= secf_d;
      tickf_q <= tickf_d;
    end
  end

endmodule

// File: tb/tb_bcd_rtc_card.sv
// Randomized and directed bench for bcd_rtc_card against a calendar model.
module tb_bcd_rtc_card;

  logic        clk = 1'b0;
  logic        RESET, PH_2, DEVICE_SELECT_N, RW_N, OE;
  logic [15:0] ADDRESS;
  logic [7:0]  DATA_IN, DATA_OUT;
  logic [64:0] RTC;

  int n_checks = 0;
  int n_fail   = 0;
  int m_yr, m_mo, m_dy, m_hr, m_mi, m_se, m_wd;

  always #5 clk = ~clk;

  bcd_rtc_card #(.CLK_HZ(600), .TICK_HZ(60), .HOLD_ON_RESET(0)) dut (
    .CLK_14M(clk), .RESET(RESET), .PH_2(PH_2), .DEVICE_SELECT_N(DEVICE_SELECT_N),
    .ADDRESS(ADDRESS), .RW_N(RW_N), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .OE(OE), .RTC(RTC));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- calendar reference model ----------------
  function automatic int m_dim(input int mo, input int yr);
    if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  task automatic m_tick();
    m_se++;  if (m_se < 60) return;
    m_se = 0; m_mi++; if (m_mi < 60) return;
    m_mi = 0; m_hr++; if (m_hr < 24) return;
    m_hr = 0; m_wd = (m_wd + 1) % 7; m_dy++;
    if (m_dy <= m_dim(m_mo, m_yr)) return;
    m_dy = 1; m_mo++; if (m_mo <= 12) return;
    m_mo = 1; m_yr = (m_yr + 1) % 100;
  endtask

  task automatic m_reset();
    m_yr = 0; m_mo = 1; m_dy = 1; m_hr = 0; m_mi = 0; m_se = 0; m_wd = 0;
  endtask

  function automatic logic [7:0] exp_reg(input int a);
    case (a)
      0:  return 8'h32;
      1:  return 8'h30;
      2:  return 8'h30 | 8'(m_yr / 10);
      3:  return 8'h30 | 8'(m_yr % 10);
      4:  return 8'(m_mo / 10);
      5:  return 8'h30 | 8'(m_mo % 10);
      6:  return 8'(m_wd);
      7:  return 8'(m_dy / 10);
      8:  return 8'h30 | 8'(m_dy % 10);
      9:  return 8'(m_hr / 10);
      10: return 8'h30 | 8'(m_hr % 10);
      11: return 8'(m_mi / 10);
      12: return 8'h30 | 8'(m_mi % 10);
      13: return 8'(m_se / 10);
      14: return 8'h30 | 8'(m_se % 10);
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- bus helpers ----------------
  task automatic bus_cycle(input int a, input logic rw, input logic [7:0] d, output logic [7:0] q);
    @(negedge clk);
    ADDRESS = 16'hC0B0 | 16'(a & 15); RW_N = rw; DATA_IN = d; DEVICE_SELECT_N = 1'b0; PH_2 = 1'b1;
    @(negedge clk);
    PH_2 = 1'b0;
    #1 q = DATA_OUT;
    @(negedge clk);
    DEVICE_SELECT_N = 1'b1; RW_N = 1'b1;
  endtask

  task automatic bus_wr(input int a, input int d);
    logic [7:0] q;
    bus_cycle(a, 1'b0, 8'(d), q);
  endtask

  task automatic bus_rd(input int a, output logic [7:0] q);
    bus_cycle(a, 1'b1, 8'h00, q);
  endtask

  task automatic peek_now(input int a, output logic [7:0] q);
    ADDRESS = 16'(a & 15);
    #1 q = DATA_OUT;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] q;
    for (int a = 2; a < 15; a++) begin
      @(negedge clk);
      peek_now(a, q);
      chk($sformatf("%s_r%0h", tag, a), q, exp_reg(a));
    end
  endtask

  // Stop the clock, load every field (seconds last), leave it held
  task automatic set_time_hold(input int yr, input int mo, input int dy, input int hr,
                               input int mi, input int se, input int wd);
    m_yr = yr; m_mo = mo; m_dy = dy; m_hr = hr; m_mi = mi; m_se = se; m_wd = wd;
    bus_wr(15, 1);
    bus_wr(2, yr / 10); bus_wr(3, yr % 10);
    bus_wr(4, mo / 10); bus_wr(5, mo % 10);
    bus_wr(6, wd);
    bus_wr(7, dy / 10); bus_wr(8, dy % 10);
    bus_wr(9, hr / 10); bus_wr(10, hr % 10);
    bus_wr(11, mi / 10); bus_wr(12, mi % 10);
    bus_wr(13, se / 10); bus_wr(14, se % 10);
  endtask

  task automatic run_second(input string tag, input int yr, input int mo, input int dy,
                            input int hr, input int mi, input int se, input int wd);
    set_time_hold(yr, mo, dy, hr, mi, se, wd);
    bus_wr(15, 0);
    repeat (700) @(negedge clk);
    m_tick();
    check_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] q;
    int yr, mo, dy, hr, mi, se, wd;
    RESET = 1'b1; PH_2 = 1'b0; DEVICE_SELECT_N = 1'b1; RW_N = 1'b1;
    ADDRESS = '0; DATA_IN = '0; RTC = '0;
    m_reset();
    repeat (3) @(negedge clk);

    // reset state of the whole register map
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      peek_now(a, q);
      chk($sformatf("reset_r%0h", a), q, exp_reg(a));
    end
    DEVICE_SELECT_N = 1'b0; #1 chk("oe_sel", OE, 1'b1);
    DEVICE_SELECT_N = 1'b1; #1 chk("oe_idle", OE, 1'b0);
    @(negedge clk);
    RESET = 1'b0;

    // calendar boundaries
    run_second("y2k",      99, 12, 31, 23, 59, 59, 5);
    run_second("feb_1999", 99,  2, 28, 23, 59, 59, 2);
    run_second("feb_2000",  0,  2, 28, 23, 59, 59, 1);
    run_second("leapday",   0,  2, 29, 23, 59, 59, 6);
    run_second("apr30",    13,  4, 30, 23, 59, 59, 0);

    // randomized dates biased towards rollover points
    for (int i = 0; i < 8; i++) begin
      yr = $urandom_range(0, 99);
      mo = $urandom_range(1, 12);
      dy = $urandom_range(0, 1) ? m_dim(mo, yr) : $urandom_range(1, m_dim(mo, yr));
      hr = $urandom_range(0, 1) ? 23 : $urandom_range(0, 23);
      mi = $urandom_range(0, 1) ? 59 : $urandom_range(0, 59);
      se = $urandom_range(0, 3) != 0 ? 59 : $urandom_range(0, 59);
      wd = $urandom_range(0, 6);
      run_second($sformatf("rnd%0d", i), yr, mo, dy, hr, mi, se, wd);
    end

    // snapshot keeps the coherent copy while the live clock moves on
    set_time_hold(10, 3, 20, 8, 10, 59, 4);
    bus_wr(15, 2);
    bus_rd(0, q);
    chk("snap_r0", q, 8'h32);
    repeat (700) @(negedge clk);
    peek_now(14, q); chk("snap_sec_o", q, 8'h39);
    peek_now(13, q); chk("snap_sec_t", q, 8'h05);
    bus_wr(15, 0);
    m_tick();
    check_all("snap_live");

    // write to seconds on the carry cycle: write lands, carry follows one cycle later
    set_time_hold(5, 6, 15, 10, 20, 38, 1);
    bus_wr(15, 0);
    repeat (597) @(negedge clk);
    bus_wr(14, 9);
    m_se = 39;
    peek_now(14, q); chk("pend_wr_o", q, exp_reg(14));
    peek_now(13, q); chk("pend_wr_t", q, exp_reg(13));
    @(negedge clk);
    m_tick();
    peek_now(14, q); chk("pend_apl_o", q, exp_reg(14));
    peek_now(13, q); chk("pend_apl_t", q, exp_reg(13));

    // hold freezes everything; first carry exactly 600 cycles after release
    set_time_hold(42, 11, 7, 9, 30, 12, 3);
    bus_rd(15, q);
    repeat (3000) @(negedge clk);
    check_all("hold");
    peek_now(15, q); chk("hold_ctrl", q, 8'h01);
    bus_wr(15, 0);
    repeat (599) @(negedge clk);
    peek_now(14, q); chk("rel_599", q, exp_reg(14));
    @(negedge clk);
    m_tick();
    peek_now(14, q); chk("rel_600", q, exp_reg(14));
    peek_now(15, q); chk("rel_flags", q, 8'hC0);

    // host load toggled during a bus write to minute ones: load wins
    set_time_hold(1, 1, 1, 1, 1, 1, 1);
    @(negedge clk);
    RTC[63:0] = 64'h0003_2405_0923_5930;
    @(negedge clk);
    ADDRESS = 16'h000C; RW_N = 1'b0; DATA_IN = 8'h05; DEVICE_SELECT_N = 1'b0; PH_2 = 1'b1;
    @(negedge clk);
    PH_2 = 1'b0; RTC[64] = ~RTC[64];
    @(negedge clk);
    DEVICE_SELECT_N = 1'b1; RW_N = 1'b1;
    m_yr = 24; m_mo = 5; m_dy = 9; m_hr = 23; m_mi = 59; m_se = 30; m_wd = 3;
    check_all("load");

    // reset during an access discards it
    set_time_hold(23, 7, 4, 12, 0, 0, 2);
    @(negedge clk);
    ADDRESS = 16'h0003; RW_N = 1'b0; DATA_IN = 8'h07; DEVICE_SELECT_N = 1'b0; PH_2 = 1'b1;
    @(negedge clk);
    PH_2 = 1'b0; RESET = 1'b1;
    @(negedge clk);
    DEVICE_SELECT_N = 1'b1; RW_N = 1'b1;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    peek_now(15, q); chk("rst2_ctrl", q, 8'h00);
    m_reset();
    check_all("rst2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
